wb_write_queue: RTL and testbench



---
 rtl/wb_write_queue_if.sv | 40 ++++
 rtl/wb_write_queue.sv | 121 ++++++++++++
 tb/tb_wb_write_queue.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Handshake/bus bundle for the write-back queue.
// Carries enqueue, register-file drain, bypass lookup and status signals.
//   slave  : queue side (receives requests, drives drain/lookup/status)
//   master : producer/consumer side (drives requests, drain_en, lookups)
interface wb_write_queue_if #(
    parameter int AW = 2
);
    logic          enq_valid;
    logic          enq_ready;
    logic [4:0]    enq_reg;
    logic [31:0]   enq_data;
    logic          drain_en;
    logic          RegWrite;
    logic [4:0]    writereg;
    logic [31:0]   writedata;
    logic [4:0]    lkp1_reg;
    logic          lkp1_hit;
    logic [31:0]   lkp1_data;
    logic [4:0]    lkp2_reg;
    logic          lkp2_hit;
    logic [31:0]   lkp2_data;
    logic [AW:0]   count;
    logic          empty;

    modport slave (
        input  enq_valid, enq_reg, enq_data, drain_en,
        input  lkp1_reg, lkp2_reg,
        output enq_ready, RegWrite, writereg, writedata,
        output lkp1_hit, lkp1_data, lkp2_hit, lkp2_data,
        output count, empty
    );

    modport master (
        output enq_valid, enq_reg, enq_data, drain_en,
        output lkp1_reg, lkp2_reg,
        input  enq_ready, RegWrite, writereg, writedata,
        input  lkp1_hit, lkp1_data, lkp2_hit, lkp2_data,
        input  count, empty
    );
endinterface

// File: rtl/wb_write_queue.sv
// In-order register write-back queue draining onto one register-file port.
// Ports: clk, rst_n (async active-low), io_bus (wb_write_queue_if.slave):
//   enq_valid/enq_ready/enq_reg/enq_data  request in
//   drain_en/RegWrite/writereg/writedata  register-file write port
//   lkp{1,2}_reg/_hit/_data               newest-pending bypass lookup
//   count/empty                           occupancy
// Macro WB_QUEUE_BYPASS_EN builds the lookup; otherwise hits/data tie to 0.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_write_queue_if.slave  io_bus
);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] r_valid;
    logic [4:0]       r_reg  [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_ready;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign w_ready  = (r_count != LP_DEPTH);
    assign w_accept = io_bus.enq_valid && w_ready;
    // r0 writes complete the handshake but are dropped
    assign w_push   = w_accept && (io_bus.enq_reg != 5'd0);
    assign w_pop    = !w_empty && io_bus.drain_en;

    assign io_bus.enq_ready = w_ready;
    assign io_bus.count     = r_count;
    assign io_bus.empty     = w_empty;
    assign io_bus.RegWrite  = w_pop;
    assign io_bus.writereg  = w_empty ? 5'd0  : r_reg[r_rd_ptr];
    assign io_bus.writedata = w_empty ? 32'd0 : r_data[r_rd_ptr];

    // push and pop never target the same slot: that would need the
    // queue to be both empty (no pop) and full (no push)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // payload needs no reset; valid bits and count qualify every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_wr_ptr]  <= io_bus.enq_reg;
            r_data[r_wr_ptr] <= io_bus.enq_data;
        end
    end

`ifdef WB_QUEUE_BYPASS_EN
    logic        w_hit1;
    logic        w_hit2;
    logic [31:0] w_data1;
    logic [31:0] w_data2;

    // walk oldest to newest so a later match overrides an earlier one
    always_comb begin
        logic [AW-1:0] idx;
        w_hit1  = 1'b0;
        w_hit2  = 1'b0;
        w_data1 = 32'd0;
        w_data2 = 32'd0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_rd_ptr + AW'(i);
            if (r_valid[idx] && io_bus.lkp1_reg != 5'd0
                && r_reg[idx] == io_bus.lkp1_reg) begin
                w_hit1  = 1'b1;
                w_data1 = r_data[idx];
            end
            if (r_valid[idx] && io_bus.lkp2_reg != 5'd0
                && r_reg[idx] == io_bus.lkp2_reg) begin
                w_hit2  = 1'b1;
                w_data2 = r_data[idx];
            end
        end
    end

    assign io_bus.lkp1_hit  = w_hit1;
    assign io_bus.lkp1_data = w_data1;
    assign io_bus.lkp2_hit  = w_hit2;
    assign io_bus.lkp2_data = w_data2;
`else
    logic w_unused;
    assign w_unused = ^{io_bus.lkp1_reg, io_bus.lkp2_reg, r_valid};

    assign io_bus.lkp1_hit  = 1'b0;
    assign io_bus.lkp1_data = 32'd0;
    assign io_bus.lkp2_hit  = 1'b0;
    assign io_bus.lkp2_data = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4).
// Inputs change on the falling edge; outputs are sampled mid-phase.
module tb_wb_write_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_write_queue_if #(.AW(2)) bus ();

    wb_write_queue #(.DEPTH(4), .AW(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    task automatic idle();
        bus.enq_valid = 1'b0;
        bus.enq_reg   = 5'd0;
        bus.enq_data  = 32'd0;
        bus.drain_en  = 1'b0;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        @(negedge clk);
        bus.enq_valid = 1'b1;
        bus.enq_reg   = r;
        bus.enq_data  = d;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.lkp1_reg = 5'd0;
        bus.lkp2_reg = 5'd0;
        #3;
        n_vec++;
        if ({bus.enq_ready, bus.RegWrite, bus.empty} !== 3'b101) begin
            n_err++;
            $display("FAIL reset_flags: got %b exp 101",
                     {bus.enq_ready, bus.RegWrite, bus.empty});
        end
        n_vec++;
        if ({bus.writereg, bus.writedata, bus.count} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got %h/%h/%0d exp 0",
                     bus.writereg, bus.writedata, bus.count);
        end
        n_vec++;
        if ({bus.lkp1_hit, bus.lkp2_hit, bus.lkp1_data, bus.lkp2_data} !== '0) begin
            n_err++;
            $display("FAIL reset_lkp: got %b%b exp 00",
                     bus.lkp1_hit, bus.lkp2_hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(5'd1, 32'h1);
        push(5'd2, 32'h2);
        push(5'd3, 32'h3);
        n_vec++;
        if (bus.count !== 3'd3) begin
            n_err++;
            $display("FAIL mid_rst_pre_count: got %0d exp 3", bus.count);
        end
        bus.drain_en = 1'b1;
        #1;
        n_vec++;
        if (bus.RegWrite !== 1'b1 || bus.writereg !== 5'd1) begin
            n_err++;
            $display("FAIL mid_rst_pre_wr: got %b/%0d exp 1/1",
                     bus.RegWrite, bus.writereg);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.RegWrite, bus.count, bus.enq_ready, bus.empty} !== 6'b0_000_11) begin
            n_err++;
            $display("FAIL mid_rst: got wr=%b cnt=%0d rdy=%b emp=%b exp 0/0/1/1",
                     bus.RegWrite, bus.count, bus.enq_ready, bus.empty);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.count !== 3'd0 || bus.RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL post_rst: got cnt=%0d wr=%b exp 0/0",
                     bus.count, bus.RegWrite);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.drain_en  = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_reg   = 5'd7;
        bus.enq_data  = 32'h0000_00AA;
        #1;
        n_vec++;
        if (bus.RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL single_pre: got wr=%b exp 0", bus.RegWrite);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.RegWrite, bus.writereg, bus.writedata} !== {1'b1, 5'd7, 32'hAA}) begin
            n_err++;
            $display("FAIL single_wr: got %b/%0d/%h exp 1/7/aa",
                     bus.RegWrite, bus.writereg, bus.writedata);
        end
        @(negedge clk);
        bus.enq_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.empty, bus.RegWrite, bus.writereg} !== {1'b1, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL single_empty: got emp=%b wr=%b reg=%0d exp 1/0/0",
                     bus.empty, bus.RegWrite, bus.writereg);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_full();
        idle();
        for (int i = 1; i <= 4; i++)
            push(5'(i), 32'h100 + 32'(i));
        n_vec++;
        if (bus.count !== 3'd4 || bus.enq_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full: got cnt=%0d rdy=%b exp 4/0",
                     bus.count, bus.enq_ready);
        end
        push(5'd9, 32'h999);
        n_vec++;
        if (bus.count !== 3'd4) begin
            n_err++;
            $display("FAIL full_refuse: got cnt=%0d exp 4", bus.count);
        end
        bus.drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_vec++;
            if ({bus.RegWrite, bus.writereg, bus.writedata}
                !== {1'b1, 5'(i), 32'h100 + 32'(i)}) begin
                n_err++;
                $display("FAIL full_drain%0d: got %b/%0d/%h exp 1/%0d/%h",
                         i, bus.RegWrite, bus.writereg, bus.writedata,
                         i, 32'h100 + 32'(i));
            end
            @(negedge clk);
        end
        n_vec++;
        if (bus.empty !== 1'b1 || bus.RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL full_done: got emp=%b wr=%b exp 1/0",
                     bus.empty, bus.RegWrite);
        end
        idle();
    endtask

    task automatic test_r0_discard();
        @(negedge clk);
        bus.drain_en  = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_reg   = 5'd0;
        bus.enq_data  = 32'hDEAD;
        bus.lkp1_reg  = 5'd0;
        #1;
        n_vec++;
        if (bus.enq_ready !== 1'b1) begin
            n_err++;
            $display("FAIL r0_ready: got %b exp 1", bus.enq_ready);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.count, bus.RegWrite, bus.lkp1_hit} !== 5'b000_00) begin
            n_err++;
            $display("FAIL r0_discard: got cnt=%0d wr=%b hit=%b exp 0/0/0",
                     bus.count, bus.RegWrite, bus.lkp1_hit);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_bypass();
        idle();
        push(5'd5, 32'h11);
        push(5'd5, 32'h22);
        bus.lkp1_reg = 5'd5;
        bus.lkp2_reg = 5'd6;
        #1;
`ifdef WB_QUEUE_BYPASS_EN
        n_vec++;
        if ({bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.lkp2_data}
            !== {1'b1, 32'h22, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL byp_newest: got %b/%h %b/%h exp 1/22 0/0",
                     bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.lkp2_data);
        end
        @(negedge clk);
        bus.drain_en  = 1'b1;
        bus.enq_valid = 1'b1;
        bus.enq_reg   = 5'd6;
        bus.enq_data  = 32'h66;
        #1;
        n_vec++;
        if ({bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.writedata}
            !== {1'b1, 32'h22, 1'b0, 32'h11}) begin
            n_err++;
            $display("FAIL byp_drain: got %b/%h hit2=%b wd=%h exp 1/22 0 11",
                     bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.writedata);
        end
        @(negedge clk);
        bus.enq_valid = 1'b0;
        bus.drain_en  = 1'b0;
        #1;
        n_vec++;
        if ({bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.lkp2_data}
            !== {1'b1, 32'h22, 1'b1, 32'h66}) begin
            n_err++;
            $display("FAIL byp_after: got %b/%h %b/%h exp 1/22 1/66",
                     bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit, bus.lkp2_data);
        end
`else
        n_vec++;
        if ({bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit} !== 34'd0) begin
            n_err++;
            $display("FAIL byp_off: got %b/%h %b exp 0/0 0",
                     bus.lkp1_hit, bus.lkp1_data, bus.lkp2_hit);
        end
`endif
        @(negedge clk);
        bus.drain_en = 1'b1;
        for (int i = 0; i < 4; i++)
            @(negedge clk);
        n_vec++;
        if (bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL byp_flush: got emp=%b exp 1", bus.empty);
        end
        idle();
        bus.lkp1_reg = 5'd0;
        bus.lkp2_reg = 5'd0;
    endtask

    task automatic test_back_to_back();
        idle();
        push(5'd10, 32'd0);
        push(5'd11, 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.drain_en  = 1'b1;
            bus.enq_valid = 1'b1;
            bus.enq_reg   = 5'(12 + k);
            bus.enq_data  = 32'(k + 2);
            #1;
            n_vec++;
            if ({bus.RegWrite, bus.writereg, bus.writedata}
                !== {1'b1, 5'(10 + k), 32'(k)}) begin
                n_err++;
                $display("FAIL b2b_head%0d: got %b/%0d/%0d exp 1/%0d/%0d",
                         k, bus.RegWrite, bus.writereg, bus.writedata,
                         10 + k, k);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.count !== 3'd2) begin
                n_err++;
                $display("FAIL b2b_count%0d: got %0d exp 2", k, bus.count);
            end
        end
        @(negedge clk);
        bus.enq_reg  = 5'd0;
        bus.enq_data = 32'hBAD;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.count !== 3'd1 || bus.writereg !== 5'd19) begin
            n_err++;
            $display("FAIL b2b_r0pop: got cnt=%0d reg=%0d exp 1/19",
                     bus.count, bus.writereg);
        end
        @(negedge clk);
        bus.enq_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_empty: got %b exp 1", bus.empty);
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_r0_discard();
        test_bypass();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
